// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    // Word-aligned, sign-extended byte offset of a conditional branch.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection: jump beats branch, branch beats sequential; all adds wrap mod 2^32.
module fetch_next_pc
    import mips_fetch_pkg::*;
(
    input  logic [31:0]        pc_plus4,
    input  logic [INSTR_W-1:0] instr,
    input  logic               jump,
    input  logic               pc_src,
    output logic [31:0]        next_pc
);

    logic unused_opcode_s;
    assign unused_opcode_s = ^instr[31:26];

    // Redirect mux in priority order.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (pc_src) begin
            next_pc = pc_plus4 + branch_offset(instr[15:0]);
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register and fetch FSM (FETCH/WAIT/EXEC/HALT) with req/ack instruction memory.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               jump,
    input  logic               pc_src,
    input  logic               stall,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic               fetch_err,
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_redir
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    fetch_state_t       state_r, state_next_s;
    logic [31:0]        pc_r, pc_plus4_r, next_pc_s;
    logic [INSTR_W-1:0] instr_r;
    logic               instr_valid_r, imem_req_r, fetch_err_r;
    logic [15:0]        wait_cnt_r, wait_cnt_next_s;
    logic               accept_s, commit_s;

    fetch_next_pc u_next_pc (
        .pc_plus4 (pc_plus4_r),
        .instr    (instr_r),
        .jump     (jump),
        .pc_src   (pc_src),
        .next_pc  (next_pc_s)
    );

    // Next-state logic; ack only counts while a request is actually driven.
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        accept_s        = 1'b0;
        commit_s        = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (!imem_req_r) begin
                    // First cycle out of reset: raise the request before accepting data.
                    state_next_s = ST_FETCH;
                end else if (imem_ack) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_EXEC;
                end else begin
                    wait_cnt_next_s = 16'd0;
                    state_next_s    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_EXEC;
                end else if (wait_cnt_r == TIMEOUT_LAST) begin
                    state_next_s = ST_HALT;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + 16'd1;
                end
            end
            ST_EXEC: begin
                if (stall) begin
                    state_next_s = ST_EXEC;
                end else begin
                    commit_s     = 1'b1;
                    state_next_s = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_FETCH;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // PC, instruction latch and registered status outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            pc_plus4_r    <= RESET_PC + 32'd4;
            instr_r       <= NOP_INSTR;
            instr_valid_r <= 1'b0;
            imem_req_r    <= 1'b0;
            fetch_err_r   <= 1'b0;
            wait_cnt_r    <= 16'd0;
        end else begin
            instr_valid_r <= (state_next_s == ST_EXEC);
            imem_req_r    <= (state_next_s == ST_FETCH) || (state_next_s == ST_WAIT);
            fetch_err_r   <= fetch_err_r || (state_next_s == ST_HALT);
            wait_cnt_r    <= wait_cnt_next_s;
            if (accept_s) begin
                instr_r <= imem_rdata;
            end
            if (commit_s) begin
                pc_r       <= next_pc_s;
                pc_plus4_r <= next_pc_s + 32'd4;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_r, perf_redir_r;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_r <= 32'd0;
            perf_redir_r <= 32'd0;
        end else begin
            if (accept_s) begin
                perf_fetch_r <= perf_fetch_r + 32'd1;
            end
            if (commit_s && (jump || pc_src)) begin
                perf_redir_r <= perf_redir_r + 32'd1;
            end
        end
    end

    assign perf_fetch = perf_fetch_r;
    assign perf_redir = perf_redir_r;
`else
    assign perf_fetch = 32'h0000_0000;
    assign perf_redir = 32'h0000_0000;
`endif

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_r;
    assign fetch_err   = fetch_err_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (default build, RESET_PC=0, TIMEOUT_CYC=16).
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, jump, pc_src, stall, imem_ack, imem_req;
    logic [31:0] imem_rdata, imem_addr, instr, pc, pc_plus4, perf_fetch, perf_redir;
    logic        instr_valid, fetch_err;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] cur_pc, cur_instr, exp_fetch, exp_redir;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        int          waits;
        logic        j;
        logic        ps;
        int          stalls;
    } vec_t;
    vec_t vecs[15];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .jump(jump), .pc_src(pc_src), .stall(stall),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .imem_req(imem_req),
        .imem_addr(imem_addr), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err),
        .perf_fetch(perf_fetch), .perf_redir(perf_redir)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_perf();
`ifdef FETCH_PERF_CNT_EN
        check_vec("perf_fetch", perf_fetch, exp_fetch);
        check_vec("perf_redir", perf_redir, exp_redir);
`else
        check_vec("perf_fetch", perf_fetch, 32'h0);
        check_vec("perf_redir", perf_redir, 32'h0);
`endif
    endtask

    // Expects FETCH at exp_addr; holds ack off for 'waits' cycles, then returns 'word'.
    task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] word, input int waits);
        check_vec("fetch_req", {31'd0, imem_req}, 32'd1);
        check_vec("fetch_addr", imem_addr, exp_addr);
        check_vec("fetch_valid_lo", {31'd0, instr_valid}, 32'd0);
        for (int w = 0; w < waits; w++) begin
            tick();
            check_vec("wait_addr", imem_addr, exp_addr);
            check_vec("wait_req", {31'd0, imem_req}, 32'd1);
            check_vec("wait_valid_lo", {31'd0, instr_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h5A5A_A5A5;
        exp_fetch  = exp_fetch + 32'd1;
        cur_pc     = exp_addr;
        cur_instr  = word;
        check_vec("exec_valid", {31'd0, instr_valid}, 32'd1);
        check_vec("exec_instr", instr, word);
        check_vec("exec_pc", pc, exp_addr);
        check_vec("exec_pc_plus4", pc_plus4, exp_addr + 32'd4);
        check_vec("exec_req_lo", {31'd0, imem_req}, 32'd0);
    endtask

    // Stalls with jump toggling and stray acks, then commits with (j, ps).
    task automatic commit(input logic j, input logic ps, input int stalls);
        stall      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        for (int s = 0; s < stalls; s++) begin
            jump   = ~jump;
            pc_src = jump;
            tick();
            check_vec("stall_valid", {31'd0, instr_valid}, 32'd1);
            check_vec("stall_instr", instr, cur_instr);
            check_vec("stall_pc", pc, cur_pc);
        end
        imem_ack = 1'b0;
        stall    = 1'b0;
        jump     = j;
        pc_src   = ps;
        tick();
        jump   = 1'b0;
        pc_src = 1'b0;
        if (j || ps) exp_redir = exp_redir + 32'd1;
        check_vec("commit_valid_lo", {31'd0, instr_valid}, 32'd0);
        check_perf();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        exp_fetch = 32'd0;
        exp_redir = 32'd0;
        check_vec("rst_pc", pc, 32'h0);
        check_vec("rst_instr", instr, 32'h0);
        check_vec("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_vec("rst_req", {31'd0, imem_req}, 32'd0);
        check_vec("rst_err", {31'd0, fetch_err}, 32'd0);
        check_perf();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; jump = 1'b0; pc_src = 1'b0; stall = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        exp_fetch = 32'd0; exp_redir = 32'd0;
        cur_pc = 32'h0; cur_instr = 32'h0;

        vecs[0]  = '{32'h0000_0000, 32'h2008_0001, 0, 1'b0, 1'b0, 0};
        vecs[1]  = '{32'h0000_0004, 32'h2009_0002, 0, 1'b0, 1'b0, 0};
        vecs[2]  = '{32'h0000_0008, 32'h0109_5020, 3, 1'b0, 1'b0, 5};
        vecs[3]  = '{32'h0000_000C, 32'hAC0A_0000, 0, 1'b0, 1'b0, 0};
        vecs[4]  = '{32'h0000_0010, 32'h1000_FFFE, 0, 1'b0, 1'b1, 0};
        vecs[5]  = '{32'h0000_000C, 32'h2000_0000, 0, 1'b0, 1'b0, 0};
        vecs[6]  = '{32'h0000_0010, 32'h1000_0003, 0, 1'b0, 1'b1, 0};
        vecs[7]  = '{32'h0000_0020, 32'h1000_0037, 0, 1'b0, 1'b1, 0};
        vecs[8]  = '{32'h0000_0100, 32'h0800_0010, 0, 1'b1, 1'b1, 0};
        vecs[9]  = '{32'h0000_0040, 32'h1000_FFED, 2, 1'b0, 1'b1, 0};
        vecs[10] = '{32'hFFFF_FFF8, 32'h0800_0010, 0, 1'b0, 1'b0, 0};
        vecs[11] = '{32'hFFFF_FFFC, 32'h1000_FFFF, 0, 1'b0, 1'b0, 0};
        vecs[12] = '{32'h0000_0000, 32'h1000_FFFD, 0, 1'b0, 1'b1, 0};
        vecs[13] = '{32'hFFFF_FFF8, 32'h0800_0010, 0, 1'b1, 1'b0, 2};
        vecs[14] = '{32'hF000_0040, 32'h2008_0001, 1, 1'b0, 1'b0, 0};

        do_reset();
        foreach (vecs[i]) begin
            fetch_one(vecs[i].addr, vecs[i].word, vecs[i].waits);
            commit(vecs[i].j, vecs[i].ps, vecs[i].stalls);
        end

        // Timeout: FETCH plus 16 ack-less WAIT cycles, then HALT.
        check_vec("to_addr", imem_addr, 32'hF000_0044);
        for (int t = 0; t < 16; t++) tick();
        check_vec("to_req_before", {31'd0, imem_req}, 32'd1);
        check_vec("to_err_before", {31'd0, fetch_err}, 32'd0);
        tick();
        check_vec("halt_err", {31'd0, fetch_err}, 32'd1);
        check_vec("halt_req", {31'd0, imem_req}, 32'd0);
        check_vec("halt_valid", {31'd0, instr_valid}, 32'd0);
        imem_ack = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            check_vec("halt_err_sticky", {31'd0, fetch_err}, 32'd1);
            check_vec("halt_req_sticky", {31'd0, imem_req}, 32'd0);
        end
        imem_ack = 1'b0;

        do_reset();
        fetch_one(32'h0000_0000, 32'h2008_0007, 0);
        commit(1'b0, 1'b0, 0);

        // Reset in the middle of a WAIT abandons the request.
        check_vec("mid_addr", imem_addr, 32'h0000_0004);
        tick();
        tick();
        do_reset();
        fetch_one(32'h0000_0000, 32'h2009_0009, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
